// File: rtl/bnn_accum_ctrl_if.sv
// Handshake and data bundle for bnn_accum_ctrl.
//   master : the beat source / consumer side. It drives start, num_beats, bias, in_valid,
//            tree_sum and out_ready.
//   slave  : the controller. It drives in_ready, tree_issue, out_valid, out_sum, out_bit
//            and busy.
// Signal widths follow WIDTH_IN and BEATS_W:
//   tree_sum is WIDTH_IN+11 bits.
//   bias and out_sum are ACC_W = WIDTH_IN+11+BEATS_W bits.
interface bnn_accum_ctrl_if #(
    parameter int unsigned WIDTH_IN = 8,
    parameter int unsigned BEATS_W  = 6
);
    localparam int unsigned TREE_W = WIDTH_IN + 11;
    localparam int unsigned ACC_W  = TREE_W + BEATS_W;

    logic                     start;
    logic [BEATS_W-1:0]       num_beats;
    logic signed [ACC_W-1:0]  bias;
    logic                     in_valid;
    logic                     in_ready;
    logic                     tree_issue;
    logic signed [TREE_W-1:0] tree_sum;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [ACC_W-1:0]  out_sum;
    logic                     out_bit;
    logic                     busy;

    modport master (
        output start, num_beats, bias, in_valid, tree_sum, out_ready,
        input  in_ready, tree_issue, out_valid, out_sum, out_bit, busy
    );

    modport slave (
        input  start, num_beats, bias, in_valid, tree_sum, out_ready,
        output in_ready, tree_issue, out_valid, out_sum, out_bit, busy
    );
endinterface

// File: rtl/bnn_accum_ctrl.sv
// Sequences one neuron's dot product through a pipelined adder tree. The block works in
// these steps:
//   1. It accepts num_beats input beats.
//   2. It tracks their sums through the tree with a latency-matched valid shift register.
//   3. It accumulates each sum onto a bias.
//   4. It hands the result and its sign bit to the consumer on a valid/ready handshake.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus_io : bnn_accum_ctrl_if.slave. It carries the start/config inputs, the beat
//            handshake, tree_sum, the result handshake and busy.
module bnn_accum_ctrl #(
    parameter int unsigned WIDTH_IN = 8,
    parameter int unsigned TREE_LAT = 4,
    parameter int unsigned BEATS_W  = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    bnn_accum_ctrl_if.slave bus_io
);
    localparam int unsigned TREE_W = WIDTH_IN + 11;
    localparam int unsigned ACC_W  = TREE_W + BEATS_W;
    // Selects the output tap of the valid shift register. Written so TREE_LAT=1 still works.
    localparam logic [TREE_LAT-1:0] LastTap = TREE_LAT'(1) << (TREE_LAT - 1);

    typedef enum logic [1:0] {StIdle, StFeed, StDrain, StDone} state_e;

    state_e                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [BEATS_W-1:0]      cnt_q, cnt_d;
    logic [BEATS_W-1:0]      nb_q, nb_d;
    logic [TREE_LAT-1:0]     vld_q, vld_d;

    logic                    in_ready;
    logic                    issue;
    logic                    tap_valid;
    logic                    earlier_pending;
    logic signed [ACC_W-1:0] sum_ext;

    always_comb begin
        in_ready        = (state_q == StFeed);
        issue           = bus_io.in_valid & in_ready;
        tap_valid       = |(vld_q & LastTap);
        earlier_pending = |(vld_q & ~LastTap);
        sum_ext         = {{BEATS_W{bus_io.tree_sum[TREE_W-1]}}, bus_io.tree_sum};

        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        nb_d    = nb_q;
        // The valid shift register runs in every state.
        // A shift instead of a slice keeps TREE_LAT=1 legal.
        vld_d   = (vld_q << 1) | TREE_LAT'(issue);

        // A sum arriving on the tap is accumulated in whatever state we are in.
        // Only FEED and DRAIN can actually see one.
        if (tap_valid) begin
            acc_d = acc_q + sum_ext;
        end

        unique case (state_q)
            StIdle: begin
                if (bus_io.start) begin
                    nb_d    = bus_io.num_beats;
                    acc_d   = bus_io.bias;
                    cnt_d   = '0;
                    state_d = (bus_io.num_beats == '0) ? StDone : StFeed;
                end
            end
            StFeed: begin
                if (issue) begin
                    cnt_d = cnt_q + BEATS_W'(1);
                    if (cnt_q == nb_q - BEATS_W'(1)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // No new beats enter in DRAIN. A lone sum on the tap is therefore the last one.
                if (tap_valid && !earlier_pending) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus_io.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
            nb_q    <= '0;
            vld_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            nb_q    <= nb_d;
            vld_q   <= vld_d;
        end
    end

    // The result outputs are gated by DONE. This keeps out_bit at 0 in reset and idle even
    // though ~acc[MSB] would be 1 there.
    assign bus_io.in_ready   = in_ready;
    assign bus_io.tree_issue = issue;
    assign bus_io.out_valid  = (state_q == StDone);
    assign bus_io.out_sum    = (state_q == StDone) ? acc_q : '0;
    assign bus_io.out_bit    = (state_q == StDone) & ~acc_q[ACC_W-1];
    assign bus_io.busy       = (state_q != StIdle);
endmodule

// File: tb/tb_bnn_accum_ctrl.sv
module tb_bnn_accum_ctrl;
    localparam int unsigned WIDTH_IN = 8;
    localparam int unsigned TREE_LAT = 4;
    localparam int unsigned BEATS_W  = 6;
    localparam int unsigned TREE_W   = WIDTH_IN + 11;
    localparam int unsigned ACC_W    = TREE_W + BEATS_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_total = 0;
    int   n_pass  = 0;

    bnn_accum_ctrl_if #(.WIDTH_IN(WIDTH_IN), .BEATS_W(BEATS_W)) bus ();

    bnn_accum_ctrl #(
        .WIDTH_IN(WIDTH_IN),
        .TREE_LAT(TREE_LAT),
        .BEATS_W (BEATS_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus_io(bus)
    );

    always #5 clk = ~clk;

    // Move to 1 time unit after the next rising edge; inputs are driven from here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start     = 1'b0;
        bus.num_beats = '0;
        bus.bias      = '0;
        bus.in_valid  = 1'b0;
        bus.tree_sum  = TREE_W'(19'h2AAAA);
        bus.out_ready = 1'b0;
    endtask

    // Pulse start for one IDLE cycle, then leave junk on the config inputs.
    // Return in cycle 0 of the neuron.
    task automatic launch(input logic [BEATS_W-1:0] nb, input logic signed [ACC_W-1:0] b);
        bus.start     = 1'b1;
        bus.num_beats = nb;
        bus.bias      = b;
        step();
        bus.start     = 1'b0;
        bus.num_beats = BEATS_W'(17);
        bus.bias      = ACC_W'(999);
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        #12;
        n_total++;
        if ({bus.in_ready, bus.tree_issue, bus.out_valid, bus.busy, bus.out_bit} !== 5'b0)
            $display("FAIL reset_flags: got %b expected 00000",
                     {bus.in_ready, bus.tree_issue, bus.out_valid, bus.busy, bus.out_bit});
        else n_pass++;
        n_total++;
        if (bus.out_sum !== ACC_W'(0))
            $display("FAIL reset_sum: got %0d expected 0", bus.out_sum);
        else n_pass++;
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_beat();
        launch(BEATS_W'(1), ACC_W'(0));
        for (int k = 0; k <= 5; k++) begin
            bus.in_valid = (k == 0);
            bus.tree_sum = (k == 4) ? TREE_W'(37) : TREE_W'(19'h45A5A);
            #1;
            if (k == 0) begin
                n_total++;
                if ({bus.in_ready, bus.tree_issue} !== 2'b11)
                    $display("FAIL single_issue: got %b expected 11",
                             {bus.in_ready, bus.tree_issue});
                else n_pass++;
            end
            n_total++;
            if (bus.out_valid !== (k == 5))
                $display("FAIL single_valid_c%0d: got %b expected %b", k, bus.out_valid, k == 5);
            else n_pass++;
            if (k < 5) step();
        end
        n_total++;
        if ({bus.out_sum, bus.out_bit} !== {ACC_W'(37), 1'b1})
            $display("FAIL single_result: got %0d/%b expected 37/1", bus.out_sum, bus.out_bit);
        else n_pass++;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        #1;
        n_total++;
        if ({bus.out_valid, bus.busy} !== 2'b00)
            $display("FAIL single_handoff: got %b expected 00", {bus.out_valid, bus.busy});
        else n_pass++;
    endtask

    task automatic test_multi_beat();
        logic [10:0]              iv;
        logic signed [TREE_W-1:0] ts [11];
        iv = 11'b000_0010_0101;  // issue cycles 0, 2, 5
        for (int k = 0; k < 11; k++) ts[k] = TREE_W'(k * 7919 + 12345);
        ts[4] = TREE_W'(100);
        ts[6] = TREE_W'(-250);
        ts[9] = TREE_W'(20);
        step();
        launch(BEATS_W'(3), ACC_W'(50));
        for (int k = 0; k <= 10; k++) begin
            bus.in_valid = iv[k];
            bus.tree_sum = ts[k];
            #1;
            n_total++;
            if (bus.out_valid !== (k == 10))
                $display("FAIL multi_valid_c%0d: got %b expected %b", k, bus.out_valid, k == 10);
            else n_pass++;
            n_total++;
            if (bus.in_ready !== (k <= 5))
                $display("FAIL multi_ready_c%0d: got %b expected %b", k, bus.in_ready, k <= 5);
            else n_pass++;
            if (k < 10) step();
        end
        n_total++;
        if ({bus.out_sum, bus.out_bit} !== {ACC_W'(-80), 1'b0})
            $display("FAIL multi_result: got %0d/%b expected -80/0", bus.out_sum, bus.out_bit);
        else n_pass++;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_zero_beats();
        launch(BEATS_W'(0), ACC_W'(-3));
        bus.in_valid = 1'b1;
        #1;
        n_total++;
        if ({bus.out_valid, bus.in_ready, bus.tree_issue, bus.out_bit} !== 4'b1000)
            $display("FAIL zero_flags: got %b expected 1000",
                     {bus.out_valid, bus.in_ready, bus.tree_issue, bus.out_bit});
        else n_pass++;
        n_total++;
        if (bus.out_sum !== ACC_W'(-3))
            $display("FAIL zero_sum: got %0d expected -3", bus.out_sum);
        else n_pass++;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        launch(BEATS_W'(0), ACC_W'(77));
        for (int k = 0; k < 6; k++) begin
            bus.start     = (k == 2);
            bus.num_beats = BEATS_W'(3);
            bus.bias      = ACC_W'(-9);
            #1;
            n_total++;
            if ({bus.out_valid, bus.out_bit, bus.busy, bus.out_sum} !== {3'b111, ACC_W'(77)})
                $display("FAIL bp_hold_c%0d: got %b%b%b/%0d expected 111/77", k,
                         bus.out_valid, bus.out_bit, bus.busy, bus.out_sum);
            else n_pass++;
            step();
        end
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        n_total++;
        if ({bus.out_valid, bus.out_sum} !== {1'b1, ACC_W'(77)})
            $display("FAIL bp_release: got %b/%0d expected 1/77", bus.out_valid, bus.out_sum);
        else n_pass++;
        step();
        bus.out_ready = 1'b0;
        #1;
        n_total++;
        if ({bus.out_valid, bus.busy} !== 2'b00)
            $display("FAIL bp_idle: got %b expected 00", {bus.out_valid, bus.busy});
        else n_pass++;
        step();
        n_total++;
        if ({bus.out_valid, bus.busy} !== 2'b00)
            $display("FAIL bp_no_restart: got %b expected 00", {bus.out_valid, bus.busy});
        else n_pass++;
    endtask

    task automatic test_max_length();
        launch(BEATS_W'(63), ACC_W'(0));
        bus.tree_sum = TREE_W'(19'h40000);  // -(2^18)
        for (int k = 0; k <= 67; k++) begin
            bus.in_valid = (k < 63);
            #1;
            n_total++;
            if (bus.in_ready !== (k < 63))
                $display("FAIL max_ready_c%0d: got %b expected %b", k, bus.in_ready, k < 63);
            else n_pass++;
            if (k >= 66) begin
                n_total++;
                if (bus.out_valid !== (k == 67))
                    $display("FAIL max_valid_c%0d: got %b expected %b", k, bus.out_valid, k == 67);
                else n_pass++;
            end
            if (k < 67) step();
        end
        n_total++;
        if ({bus.out_sum, bus.out_bit} !== {ACC_W'(-63 * 262144), 1'b0})
            $display("FAIL max_result: got %0d/%b expected -16515072/0", bus.out_sum, bus.out_bit);
        else n_pass++;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_drain();
        bus.tree_sum = TREE_W'(999);
        launch(BEATS_W'(2), ACC_W'(500));
        bus.in_valid = 1'b1;
        step();
        step();
        bus.in_valid = 1'b0;
        #1;
        n_total++;
        if ({bus.in_ready, bus.busy} !== 2'b01)
            $display("FAIL rst_drain_state: got %b expected 01", {bus.in_ready, bus.busy});
        else n_pass++;
        #1;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({bus.in_ready, bus.tree_issue, bus.out_valid, bus.busy, bus.out_bit, bus.out_sum}
            !== {5'b0, ACC_W'(0)})
            $display("FAIL rst_async: got %b/%0d expected 00000/0",
                     {bus.in_ready, bus.tree_issue, bus.out_valid, bus.busy, bus.out_bit},
                     bus.out_sum);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        launch(BEATS_W'(1), ACC_W'(0));
        for (int k = 0; k <= 5; k++) begin
            bus.in_valid = (k == 0);
            bus.tree_sum = (k == 4) ? TREE_W'(5) : TREE_W'(999);
            #1;
            n_total++;
            if (bus.out_valid !== (k == 5))
                $display("FAIL rst_new_valid_c%0d: got %b expected %b", k, bus.out_valid, k == 5);
            else n_pass++;
            if (k < 5) step();
        end
        n_total++;
        if (bus.out_sum !== ACC_W'(5))
            $display("FAIL rst_new_sum: got %0d expected 5", bus.out_sum);
        else n_pass++;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        launch(BEATS_W'(1), ACC_W'(10));
        for (int k = 0; k <= 5; k++) begin
            bus.in_valid = (k == 0);
            bus.tree_sum = (k == 4) ? TREE_W'(1) : TREE_W'(-7);
            if (k < 5) step();
        end
        #1;
        n_total++;
        if ({bus.out_valid, bus.out_sum} !== {1'b1, ACC_W'(11)})
            $display("FAIL b2b_first: got %b/%0d expected 1/11", bus.out_valid, bus.out_sum);
        else n_pass++;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        #1;
        n_total++;
        if (bus.busy !== 1'b0)
            $display("FAIL b2b_idle: got %b expected 0", bus.busy);
        else n_pass++;
        launch(BEATS_W'(1), ACC_W'(-20));
        for (int k = 0; k <= 5; k++) begin
            bus.in_valid = (k == 0);
            bus.tree_sum = (k == 4) ? TREE_W'(-1) : TREE_W'(3);
            #1;
            n_total++;
            if (bus.out_valid !== (k == 5))
                $display("FAIL b2b_valid_c%0d: got %b expected %b", k, bus.out_valid, k == 5);
            else n_pass++;
            if (k < 5) step();
        end
        n_total++;
        if ({bus.out_sum, bus.out_bit} !== {ACC_W'(-21), 1'b0})
            $display("FAIL b2b_second: got %0d/%b expected -21/0", bus.out_sum, bus.out_bit);
        else n_pass++;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_multi_beat();
        test_zero_beats();
        test_backpressure();
        test_max_length();
        test_reset_mid_drain();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/bnn_accum_ctrl.md
Name: bnn_accum_ctrl

Overview:
- Sequences one neuron's dot product through the pipelined 256-lane adder tree in 256-lane beats.
- Tracks which tree outputs are valid using a latency-matched valid shift register.
- Accumulates each valid tree sum, plus a bias, into a wide accumulator.
- Presents the final pre-activation sum and its binarized sign bit on a valid/ready output handshake.
- Sits between the weight/activation beat source and the neuron output buffer.

Parameters:
WIDTH_IN, 8, base operand width; tree output width is WIDTH_IN+11
TREE_LAT, 4, adder-tree latency in cycles from input beat to tree_sum; legal range ≥1
BEATS_W, 6, width of beat counter; max beats per neuron is 2^BEATS_W-1
ACC_W (localparam), WIDTH_IN+11+BEATS_W, accumulator width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a neuron; sampled only in IDLE
num_beats  in  BEATS_W  beats in this neuron; latched on start
bias  in  signed ACC_W  initial accumulator value; latched on start
in_valid  in  1  source has a beat on the tree inputs this cycle
in_ready  out  1  controller accepts a beat
tree_issue  out  1  in_valid & in_ready; the beat enters the tree this cycle
tree_sum  in  signed WIDTH_IN+11  adder-tree output
out_valid  out  1  result available
out_ready  in  1  consumer takes result
out_sum  out  signed ACC_W  final accumulator
out_bit  out  1  binarized activation: 1 if out_sum ≥ 0, else 0
busy  out  1  state != IDLE

Behaviour:
- Reset: asynchronous, active-low. All registers clear immediately: state=IDLE, acc=0, beat count=0, valid shift register=0, out_valid=0, in_ready=0, tree_issue=0, busy=0, out_sum=0, out_bit=0 (forced 0 during reset). Reset mid-neuron abandons it; beats still in the tree are never accumulated.
- FSM states: IDLE, FEED, DRAIN, DONE.
- IDLE:
  - On start=1: latch num_beats; acc<=bias; cnt<=0.
  - num_beats==0 → DONE (result = bias).
  - Otherwise → FEED.
  - start is ignored in every other state.
- FEED:
  - in_ready=1.
  - On tree_issue: cnt++.
  - When tree_issue and cnt==num_beats-1 → DRAIN (in_ready=0 from the next cycle).
  - Bubbles (in_valid=0) are allowed at any point.
- Valid tracking:
  - vld[0]<=tree_issue; vld[i]<=vld[i-1], for i=1..TREE_LAT-1.
  - This register runs in every state.
- Accumulation:
  - In any cycle with vld[TREE_LAT-1]=1: acc<=acc+sign_extend(tree_sum) at the clock edge ending that cycle.
  - tree_sum is ignored whenever vld[TREE_LAT-1]=0.
  - Accumulation can overlap FEED; it is legal in FEED and DRAIN.
  - ACC_W guarantees no overflow for ≤2^BEATS_W-1 beats plus an in-range bias; no saturation logic.
- DRAIN:
  - Leave for DONE on the edge where the last pending sum is accumulated, i.e. vld[TREE_LAT-1]=1 and vld[TREE_LAT-2:0]=0.
  - out_valid is asserted exactly TREE_LAT+1 cycles after the last beat's tree_issue cycle.
- DONE:
  - out_valid=1; out_sum=acc; out_bit=~acc[ACC_W-1].
  - Held stable until out_ready=1, then → IDLE with out_valid=0 next cycle.
  - out_ready is ignored outside DONE.
- Back-to-back: start may be asserted in the IDLE cycle immediately after handoff. Minimum turnaround is 1 IDLE cycle between neurons.
- busy=1 in FEED, DRAIN and DONE.

Test Plan:
- Single beat: bias=0, num_beats=1, one beat, tree_sum=+37 returned TREE_LAT cycles later → out_valid exactly 5 cycles after issue; out_sum=37; out_bit=1.
- Multi-beat with bubbles: num_beats=3, beats issued on cycles 0, 2, 5; tree_sum values 100, -250, 20 (each valid only on its vld tap); bias=50 → out_sum=-80; out_bit=0; garbage tree_sum in non-valid cycles has no effect; out_valid at cycle 10.
- Zero beats: num_beats=0, bias=-3 → DONE the cycle after start; out_sum=-3; out_bit=0; in_ready never asserted.
- Backpressure: hold out_ready=0 for 6 cycles in DONE → out_valid, out_sum and out_bit are stable throughout; a start pulse during DONE is ignored; the release cycle returns to IDLE.
- Max length: num_beats=63, every tree_sum = most negative value -(2^18) → out_sum=-63·2^18 exact (no wrap); out_bit=0.
- Reset mid-DRAIN: assert rst_n=0 asynchronously with 2 beats in flight → all outputs 0 immediately. After release, a new 1-beat neuron with bias=0 and tree_sum=5 gives out_sum=5; the stale beats are not accumulated.
